// File: rtl/combo_pkg.sv
// Shared definitions for the combination-lock sender and receiver.
// Holds the state encoding and the default combination.
package combo_pkg;

    localparam int CODE_LEN = 5;
    localparam logic [CODE_LEN-1:0] DEFAULT_CODE = 5'b01011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/combo_bit_timer.sv
// Bit-period prescaler: counts while run is high and flags the last
// cycle of each period. clear forces the count back to zero.
module combo_bit_timer #(
    parameter int BIT_PERIOD = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clear,
    output logic last
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] TOP = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign last = run && (cnt == TOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clear || !run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/combo_sender.sv
// Serial combination transmitter, MSB first, one bit per BIT_PERIOD clocks.
// Define COMBO_SENDER_RESET_PULSE_EN to add a one-cycle lock_rst pulse before each code.
module combo_sender
    import combo_pkg::*;
#(
    parameter int CODE_LEN = combo_pkg::CODE_LEN,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = combo_pkg::DEFAULT_CODE,
    parameter int BIT_PERIOD = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic [CODE_LEN-1:0] code_in,
    input  logic                start,
    input  logic                abort,
    output logic                bit_out,
    output logic                bit_strobe,
    output logic                busy,
    output logic                done,
    output logic                lock_rst
);

    localparam int IW = $clog2(CODE_LEN);
    localparam logic [IW-1:0] MSB = IW'(CODE_LEN - 1);

    state_t              state, state_nxt;
    logic [CODE_LEN-1:0] code, code_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                run;
    logic                last;

    assign run = (state == SEND);

    combo_bit_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .run  (run),
        .clear(abort),
        .last (last)
    );

    // An abort wins over the strobe so the lock never sees a partial bit.
    assign bit_strobe = last && !abort;
    assign bit_out    = run && code[idx];
    assign busy       = (state == SEND) || (state == CLEAR);
    assign done       = (state == DONE);

`ifdef COMBO_SENDER_RESET_PULSE_EN
    assign lock_rst = (state == CLEAR);
`else
    assign lock_rst = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (load) begin
                    code_nxt = code_in;
                end else if (start) begin
                    idx_nxt = MSB;
`ifdef COMBO_SENDER_RESET_PULSE_EN
                    state_nxt = CLEAR;
`else
                    state_nxt = SEND;
`endif
                end
            end
            CLEAR: begin
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    if (idx == '0) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx - 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            code  <= DEFAULT_CODE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            idx   <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_combo_sender.sv
// Directed testbench for combo_sender with a small lock receiver model
// clocked by bit_strobe.
module tb_combo_sender;

`ifdef COMBO_SENDER_RESET_PULSE_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic       CLK;
    logic       RST;
    logic       load;
    logic [4:0] code_in;
    logic       start;
    logic       abort;
    logic       bit_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;
    logic       lock_rst;

    int checks = 0;
    int fails  = 0;

    combo_sender dut (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .code_in   (code_in),
        .start     (start),
        .abort     (abort),
        .bit_out   (bit_out),
        .bit_strobe(bit_strobe),
        .busy      (busy),
        .done      (done),
        .lock_rst  (lock_rst)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Lock receiver model: shifts bit_out in on each strobe.
    logic [4:0] lsr;
    int         ln;
    logic       lock_clr;
    logic       unlock;

    assign unlock = (ln >= 5) && (lsr == 5'b01011);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            lsr <= '0;
            ln  <= 0;
        end else if (lock_clr || lock_rst) begin
            lsr <= '0;
            ln  <= 0;
        end else if (bit_strobe) begin
            lsr <= {lsr[3:0], bit_out};
            if (ln < 7) ln <= ln + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    // Sends one code and checks every cycle through one idle cycle past DONE.
    task automatic run_tx(input logic [4:0] code, input int abort_at,
                          input int inj_at, input string name);
        logic [4:0] expv;
        logic [4:0] act;
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 22 + D; c++) begin
            abort = (c == abort_at);
            if (c == inj_at) begin
                start   = 1'b1;
                load    = 1'b1;
                code_in = 5'b00000;
            end
            #1;
            expv = 5'b00000;
            if (abort_at > 0 && c > abort_at) begin
                expv = 5'b00000;
            end else if (D == 1 && c == 1) begin
                expv = 5'b11000;
            end else if (c >= 1 + D && c <= 20 + D) begin
                k = c - 1 - D;
                expv[3] = 1'b1;
                expv[2] = code[4 - k / 4];
                expv[1] = (k % 4 == 3) && (c != abort_at);
            end else if (c == 21 + D) begin
                expv = 5'b00001;
            end
            act = {lock_rst, busy, bit_out, bit_strobe, done};
            checks++;
            if (act !== expv) begin
                fails++;
                $display("FAIL %s cycle %0d: got %b want %b (lock_rst busy bit_out strobe done)",
                         name, c, act, expv);
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
            load  = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({lock_rst, busy, bit_out, bit_strobe, done} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_held: got %b want 00000",
                     {lock_rst, busy, bit_out, bit_strobe, done});
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({lock_rst, busy, bit_out, bit_strobe, done} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_release: got %b want 00000",
                     {lock_rst, busy, bit_out, bit_strobe, done});
        end
    endtask

    task automatic test_default();
        run_tx(5'b01011, 0, 0, "default_code");
    endtask

    task automatic test_load();
        load    = 1'b1;
        start   = 1'b1;
        code_in = 5'b11010;
        tick();
        load  = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL load_beats_start: busy got %b want 0", busy);
        end
        tick();
        run_tx(5'b11010, 0, 0, "loaded_code");
        pulse_reset();
        run_tx(5'b01011, 0, 0, "reset_reverts_code");
    endtask

    task automatic test_lock();
        lock_clr = 1'b1;
        tick();
        lock_clr = 1'b0;
        run_tx(5'b01011, 0, 0, "lock_good");
        checks++;
        if (unlock !== 1'b1) begin
            fails++;
            $display("FAIL lock_unlock: got %b want 1", unlock);
        end
        load    = 1'b1;
        code_in = 5'b01111;
        lock_clr = 1'b1;
        tick();
        load     = 1'b0;
        lock_clr = 1'b0;
        run_tx(5'b01111, 0, 0, "lock_bad");
        checks++;
        if (unlock !== 1'b0) begin
            fails++;
            $display("FAIL lock_stays_locked: got %b want 0", unlock);
        end
        pulse_reset();
    endtask

    task automatic test_abort();
        run_tx(5'b01011, 6, 0, "abort");
        run_tx(5'b01011, 0, 0, "after_abort");
    endtask

    task automatic test_busy_ignore();
        run_tx(5'b01011, 0, 3, "ignore_in_send");
        run_tx(5'b01011, 0, 21 + D, "ignore_in_done");
        run_tx(5'b01011, 0, 0, "code_kept");
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_bit3_busy: got %b want 1", busy);
        end
        RST = 1'b1;
        #2;
        checks++;
        if ({lock_rst, busy, bit_out, bit_strobe, done} !== 5'b00000) begin
            fails++;
            $display("FAIL async_reset: got %b want 00000",
                     {lock_rst, busy, bit_out, bit_strobe, done});
        end
        tick();
        RST = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL no_done_after_reset: got %b want 00", {busy, done});
        end
        run_tx(5'b01011, 0, 0, "after_async_reset");
    endtask

    initial begin
        RST      = 1'b1;
        load     = 1'b0;
        code_in  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        lock_clr = 1'b0;
        test_reset();
        test_default();
        test_load();
        test_lock();
        test_abort();
        test_busy_ignore();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/combo_sender.md
Name: combo_sender

Overview:
Serial code transmitter for the combination-lock keypad path. It shifts a stored or loaded combination out MSB-first on a single button line, one bit per BIT_PERIOD clocks. Each bit comes with a strobe that the lock FSM uses as its clock enable. The block sits between a control/test source and the combination-lock receiver, driving its `in` input.

Parameters:
- CODE_LEN, 5, number of bits in a combination (2..16).
- DEFAULT_CODE, 5'b01011, code register value after reset.
- BIT_PERIOD, 4, clocks each bit is held on bit_out (2..255).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- load  input  1  when idle, capture code_in into the code register.
- code_in  input  CODE_LEN  new combination, sent MSB first.
- start  input  1  single-cycle request to transmit the stored code.
- abort  input  1  synchronous cancel of an in-progress transmission.
- bit_out  output  1  serial button value to the lock's `in`.
- bit_strobe  output  1  high on the last cycle of each bit period; the lock samples on it.
- busy  output  1  high while transmitting.
- done  output  1  one-cycle pulse after the final bit completes.
- lock_rst  output  1  lock reset pulse; only active when RESET_PULSE_EN is defined.

Behaviour:
- Reset (async):
  - state=IDLE, code register=DEFAULT_CODE, counters=0.
  - bit_out=0, bit_strobe=0, busy=0, done=0, lock_rst=0.
- Reset asserted mid-transmission: outputs return to reset values immediately. No done pulse.
- States are IDLE, SEND and DONE, plus CLEAR when RESET_PULSE_EN is defined.
- IDLE:
  - load=1 captures code_in on the same edge.
  - start=1 on edge k enters SEND. At edge k+1: busy=1, bit_out=code[CODE_LEN-1], period counter=0, bit index=CODE_LEN-1.
  - load and start together: load wins; start is ignored that cycle.
- SEND:
  - The period counter increments each clock.
  - bit_strobe=1 combinationally while counter==BIT_PERIOD-1.
  - On the strobe edge the counter wraps to 0. If bit index>0, it decrements and bit_out takes the next lower bit. If bit index==0, go to DONE.
  - bit_out is stable for exactly BIT_PERIOD cycles per bit.
  - busy stays high for CODE_LEN*BIT_PERIOD cycles.
- DONE (one cycle):
  - done=1, busy=0, bit_out=0.
  - Next state IDLE.
  - A start during DONE is ignored.
- Ignored while busy: start and load. The code register is never modified mid-transmission.
- abort=1 in SEND or CLEAR, on the next edge:
  - state goes to IDLE; bit_out=0, busy=0.
  - No strobe that cycle and no done pulse.
  - abort in IDLE or DONE has no effect.
- Counter width is clog2(BIT_PERIOD); bit index width is clog2(CODE_LEN). No arithmetic overflow is possible given the parameter ranges.

Optional Feature:
- Macro: COMBO_SENDER_RESET_PULSE_EN.
- Defined:
  - start moves IDLE to CLEAR instead of SEND.
  - CLEAR lasts one cycle, with lock_rst=1, busy=1, bit_out=0 and no strobe.
  - CLEAR then enters SEND, so the first bit is delayed by one cycle.
  - This guarantees the lock begins from its ENTER state.
- Undefined: no CLEAR state; lock_rst is tied to 0.

Decomposition:
- Package combo_pkg:
  - state enum (IDLE, CLEAR, SEND, DONE);
  - DEFAULT_CODE constant 5'b01011;
  - CODE_LEN constant 5.
  - The lock receiver shares these.
- One sub-module is natural: combo_bit_timer. It is the BIT_PERIOD prescaler, with inputs run/clear and output last (the strobe).
- Shift/index logic and the FSM stay in the top module.

Test Plan:
1. Reset; start at edge 0 with BIT_PERIOD=4 -> bit_out = 0,1,0,1,1, each held 4 cycles. Strobes occur on cycles 4,8,12,16,20 after start. busy high cycles 1-20; done=1 on cycle 21.
2. load code_in=5'b11010, then start -> bit_out sequence 1,1,0,1,0. Reset again -> code register reverts to 01011.
3. Connect to the lock receiver (its clock enable = bit_strobe) and send 01011 -> lock unlock asserts on the 5th strobe. Send 01111 -> unlock never asserts.
4. abort on cycle 6 of a transmission -> busy=0 and bit_out=0 from cycle 7. No done pulse; no further strobes. A subsequent start transmits the full code.
5. start asserted during busy; load with 5'b00000 during busy -> both ignored. The transmission completes unchanged and the code register still holds 01011.
6. RST asserted mid-bit 3 -> all outputs 0 asynchronously before the next edge. With COMBO_SENDER_RESET_PULSE_EN defined, start -> lock_rst=1 on cycle 1, first strobe on cycle 5, done on cycle 22.
